fetch_stage: RTL

Instruction-fetch stage with integrated IF/ID pipeline register for the five-stage pipeline. It holds the PC and issues one-outstanding requests to instruction memory. It applies stalls from the hazard unit and redirects from the branch/jump resolution logic. It presents the fetched instruction and its PC to the decode-stage control unit, substituting a NOP bubble whenever no valid instruction is available.

---
 rtl/fetch_stage.sv | 113 +++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// Fetch stage + IF/ID register: one outstanding imem request, IF/ID valid two edges after REQ with 1-cycle memory.
// Stall parks a returned word in a holding register; redirect flushes IF/ID and drains any in-flight response.
module fetch_stage #(
    parameter int              PC_W     = 9,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            redirect,
    input  logic [PC_W-1:0] redirect_target,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    input  logic            imem_rvalid,
    output logic [31:0]     ifid_instr,
    output logic [PC_W-1:0] ifid_pc,
    output logic            ifid_valid
);
    // ADDI x0,x0,0; all-zero would decode as a load
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD, S_DRAIN} state_t;

    state_t          r_state, w_state_nxt;
    logic [PC_W-1:0] r_pc, w_pc_nxt;
    logic [PC_W-1:0] r_ifid_pc, w_ifid_pc_nxt;
    logic [31:0]     r_hold, w_hold_nxt;
    logic [31:0]     r_instr, w_instr_nxt;
    logic            r_valid, w_valid_nxt;
    logic [PC_W-1:0] w_pc_inc;
    logic [PC_W-1:0] w_target;
    logic            w_unused_tgt_lsb;

    assign w_pc_inc         = r_pc + PC_W'(4);
    assign w_target         = {redirect_target[PC_W-1:2], 2'b00};
    assign w_unused_tgt_lsb = ^redirect_target[1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_pc      <= RESET_PC;
            r_hold    <= '0;
            r_instr   <= NOP;
            r_ifid_pc <= '0;
            r_valid   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_pc      <= w_pc_nxt;
            r_hold    <= w_hold_nxt;
            r_instr   <= w_instr_nxt;
            r_ifid_pc <= w_ifid_pc_nxt;
            r_valid   <= w_valid_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_pc_nxt      = r_pc;
        w_hold_nxt    = r_hold;
        w_instr_nxt   = r_instr;
        w_ifid_pc_nxt = r_ifid_pc;
        w_valid_nxt   = r_valid;
        if (redirect) begin
            // A response still owed by memory must be swallowed before re-requesting
            w_pc_nxt    = w_target;
            w_instr_nxt = NOP;
            w_valid_nxt = 1'b0;
            w_hold_nxt  = '0;
            w_state_nxt = ((r_state == S_WAIT || r_state == S_DRAIN) && !imem_rvalid)
                          ? S_DRAIN : S_REQ;
        end else begin
            case (r_state)
                S_IDLE: w_state_nxt = S_REQ;
                S_REQ:  w_state_nxt = S_WAIT;
                S_WAIT: begin
                    if (imem_rvalid) begin
                        if (stall) begin
                            w_hold_nxt  = imem_rdata;
                            w_state_nxt = S_HOLD;
                        end else begin
                            w_instr_nxt   = imem_rdata;
                            w_ifid_pc_nxt = r_pc;
                            w_valid_nxt   = 1'b1;
                            w_pc_nxt      = w_pc_inc;
                            w_state_nxt   = S_REQ;
                        end
                    end
                end
                S_HOLD: begin
                    if (!stall) begin
                        w_instr_nxt   = r_hold;
                        w_ifid_pc_nxt = r_pc;
                        w_valid_nxt   = 1'b1;
                        w_pc_nxt      = w_pc_inc;
                        w_state_nxt   = S_REQ;
                    end
                end
                S_DRAIN: begin
                    if (imem_rvalid) w_state_nxt = S_REQ;
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    assign imem_req   = (r_state == S_REQ);
    assign imem_addr  = r_pc;
    assign ifid_instr = r_instr;
    assign ifid_pc    = r_ifid_pc;
    assign ifid_valid = r_valid;

endmodule
